// File: rtl/apb_param_pkg.sv
// +--------------------------------------------------------------------------+
// | apb_param_pkg                                                            |
// | Shared types, register indices and address helpers for apb_param_slave.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package apb_param_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   localparam int CTRL_IDX   = 0;
   localparam int STATUS_IDX = 1;

   // Byte-offset bits that select a lane within one data word.
   function automatic int lsb_shift(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

`default_nettype wire

// File: rtl/apb_sat_counter.sv
// +--------------------------------------------------------------------------+
// | apb_sat_counter                                                          |
// | Up-counter that sticks at all-ones; cleared only by reset.               |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module apb_sat_counter #(
   parameter int W = 16
) (
   input  logic         pclk,
   input  logic         prst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge pclk or negedge prst) begin
      if (!prst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/apb_param_slave.sv
// +--------------------------------------------------------------------------+
// | apb_param_slave                                                          |
// | APB completer with CTRL/STATUS/general registers, programmable waits,    |
// | PSLVERR reporting and saturating transfer/error counters.                |
// | Optional: APB_PSTRB_EN adds the pstrb port and byte-lane write masking.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module apb_param_slave
   import apb_param_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int MAX_WAIT = 7
) (
   input  logic                pclk,
   input  logic                prst,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_PSTRB_EN
   input  logic [DATA_W/8-1:0] pstrb,
`endif
   output logic [DATA_W-1:0]   prdata,
   output logic                pready,
   output logic                pslverr
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int LSB    = lsb_shift(DATA_W);
   localparam int HALF_W = DATA_W / 2;
   localparam int RIDX_W = $clog2(NUM_REGS);
   localparam int STRB_W = DATA_W / 8;
   localparam logic [ADDR_W:0] IDX_LIMIT = (ADDR_W + 1)'(NUM_REGS);

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
   logic [WAIT_W-1:0]   ctrl_q, ctrl_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];

   logic [ADDR_W-1:0]   idx;
   logic [RIDX_W-1:0]   ridx;
   logic                idx_ok;
   logic                misaligned;
   logic                is_ctrl;
   logic                is_status;
   logic                acc_err;
   logic                complete;
   logic [DATA_W-1:0]   rdata;
   logic [DATA_W-1:0]   wmask;
   logic [DATA_W-1:0]   wval;
   logic [HALF_W-1:0]   xfer_cnt;
   logic [HALF_W-1:0]   err_cnt;

   assign idx        = paddr >> LSB;
   assign ridx       = idx[RIDX_W-1:0];
   assign idx_ok     = ({1'b0, idx} < IDX_LIMIT);
   assign misaligned = (paddr[LSB-1:0] != '0);
   assign is_ctrl    = (idx == ADDR_W'(CTRL_IDX));
   assign is_status  = (idx == ADDR_W'(STATUS_IDX));
   assign acc_err    = misaligned || !idx_ok || (pwrite && is_status);
   assign complete   = (state_q == ACCESS) && psel && penable && (wcnt_q == '0);

`ifdef APB_PSTRB_EN
   for (genvar i = 0; i < STRB_W; i++) begin : g_strb
      assign wmask[8*i +: 8] = {8{pstrb[i]}};
   end
`else
   assign wmask = '1;
`endif

   always_comb begin
      rdata = '0;
      if (is_ctrl) begin
         rdata[WAIT_W-1:0] = ctrl_q;
      end else if (is_status) begin
         rdata = {err_cnt, xfer_cnt};
      end else if (idx_ok) begin
         rdata = regs_q[ridx];
      end
   end

   // State register
   always_ff @(posedge pclk or negedge prst) begin
      if (!prst) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Next state; the wait count is captured from CTRL in the setup cycle
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = ACCESS;
               wcnt_d  = ctrl_q;
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (penable) begin
               if (wcnt_q != '0) begin
                  wcnt_d = wcnt_q - WAIT_W'(1);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      pready  = complete;
      pslverr = complete && acc_err;
      prdata  = '0;
      if (complete && !acc_err && !pwrite) begin
         prdata = rdata;
      end
   end

   // Register file write path; CTRL saturates on the full written word
   always_comb begin
      wval   = (rdata & ~wmask) | (pwdata & wmask);
      ctrl_d = ctrl_q;
      regs_d = regs_q;
      if (complete && pwrite && !acc_err) begin
         if (is_ctrl) begin
            if (wval > DATA_W'(MAX_WAIT)) begin
               ctrl_d = WAIT_W'(MAX_WAIT);
            end else begin
               ctrl_d = wval[WAIT_W-1:0];
            end
         end else begin
            regs_d[ridx] = wval;
         end
      end
   end

   always_ff @(posedge pclk or negedge prst) begin
      if (!prst) begin
         ctrl_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         ctrl_q <= ctrl_d;
         regs_q <= regs_d;
      end
   end

   apb_sat_counter #(.W(HALF_W)) u_xfer_cnt (
      .pclk  (pclk),
      .prst  (prst),
      .inc   (complete),
      .count (xfer_cnt)
   );

   apb_sat_counter #(.W(HALF_W)) u_err_cnt (
      .pclk  (pclk),
      .prst  (prst),
      .inc   (complete && acc_err),
      .count (err_cnt)
   );

endmodule

`default_nettype wire

// File: tb/tb_apb_param_slave.sv
// +--------------------------------------------------------------------------+
// | tb_apb_param_slave                                                       |
// | Directed and random APB traffic against a register-level model.          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_apb_param_slave;

   logic        pclk;
   logic        prst;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
`ifdef APB_PSTRB_EN
   logic [3:0]  pstrb;
`endif
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int checks = 0;
   int errors = 0;

   // Register-level model of the completer
   logic [31:0] m_mem [16];
   int          m_ctrl;
   int          m_xfer;
   int          m_err;

   apb_param_slave #(
      .ADDR_W   (8),
      .DATA_W   (32),
      .NUM_REGS (16),
      .MAX_WAIT (7)
   ) dut (
      .pclk    (pclk),
      .prst    (prst),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
`ifdef APB_PSTRB_EN
      .pstrb   (pstrb),
`endif
      .prdata  (prdata),
      .pready  (pready),
      .pslverr (pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
      m_ctrl = 0;
      m_xfer = 0;
      m_err  = 0;
   endtask

   function automatic logic [31:0] m_read(input int idx);
      if (idx == 0) return 32'(m_ctrl);
      if (idx == 1) return {m_err[15:0], m_xfer[15:0]};
      return m_mem[idx];
   endfunction

   // One APB transfer starting at the next clock; returns access-phase length
   task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                       output int lat, output logic err, output logic [31:0] rd,
                       output bit quiet);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
      @(posedge pclk); #1;
      penable = 1'b1;
      lat   = 0;
      quiet = 1'b1;
      do begin
         @(negedge pclk);
         lat++;
         if (!pready && (prdata !== 32'h0 || pslverr !== 1'b0)) quiet = 1'b0;
      end while (pready !== 1'b1 && lat < 20);
      err = pslverr;
      rd  = prdata;
   endtask

   task automatic do_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input string tag,
                          output logic [31:0] rd);
      int          idx;
      bit          e;
      int          exp_lat;
      logic [31:0] exp_rd;
      logic [31:0] v;
      int          lat;
      logic        err;
      bit          quiet;
`ifdef APB_PSTRB_EN
      pstrb = strb;
`else
      strb = 4'hF;
`endif
      idx     = int'(addr >> 2);
      e       = (addr[1:0] != 2'b00) || (idx >= 16) || (wr && idx == 1);
      exp_lat = m_ctrl + 1;
      exp_rd  = (e || wr) ? 32'h0 : m_read(idx);
      xfer(wr, addr, data, lat, err, rd, quiet);
      check({tag, "/latency"}, lat, exp_lat);
      check({tag, "/pslverr"}, err, e);
      if (!wr) check({tag, "/prdata"}, rd, exp_rd);
      check({tag, "/quiet_before_ready"}, quiet, 1'b1);
      if (wr && !e) begin
         v = m_read(idx);
         for (int b = 0; b < 4; b++) if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
         if (idx == 0) m_ctrl = (v > 7) ? 7 : int'(v);
         else          m_mem[idx] = v;
      end
      if (m_xfer < 65535) m_xfer++;
      if (e && m_err < 65535) m_err++;
   endtask

   task automatic go_idle();
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      bit          w;
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;

      prst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 8'h0; pwdata = 32'h0;
`ifdef APB_PSTRB_EN
      pstrb = 4'h0;
`endif
      model_reset();
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("reset/pready", pready, 1'b0);
      check("reset/pslverr", pslverr, 1'b0);
      check("reset/prdata", prdata, 32'h0);
      @(posedge pclk); #1;
      prst = 1'b1;

      // penable without a setup cycle must be ignored
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h08;
      @(negedge pclk);
      check("protocol/pready1", pready, 1'b0);
      @(posedge pclk); #1;
      @(negedge pclk);
      check("protocol/pready2", pready, 1'b0);

      do_xfer(1'b0, 8'h08, 32'h0, 4'hF, "rd_idx2", rd);
      do_xfer(1'b1, 8'h00, 32'h3, 4'hF, "wr_ctrl3", rd);
      do_xfer(1'b1, 8'h0C, 32'hDEAD_BEEF, 4'hF, "wr_idx3", rd);
      do_xfer(1'b0, 8'h0C, 32'h0, 4'hF, "rd_idx3", rd);
      check("rd_idx3/value", rd, 32'hDEAD_BEEF);
      do_xfer(1'b1, 8'h00, 32'hFF, 4'hF, "wr_ctrl_ff", rd);
      do_xfer(1'b0, 8'h00, 32'h0, 4'hF, "rd_ctrl_sat", rd);
      check("rd_ctrl_sat/value", rd, 32'h7);
      do_xfer(1'b0, 8'h40, 32'h0, 4'hF, "err_oob", rd);
      do_xfer(1'b0, 8'h09, 32'h0, 4'hF, "err_misaligned", rd);
      do_xfer(1'b1, 8'h04, 32'h1234_5678, 4'hF, "err_wr_status", rd);
      do_xfer(1'b0, 8'h04, 32'h0, 4'hF, "rd_status", rd);
      check("rd_status/errcount", rd[31:16], 16'd3);
      do_xfer(1'b1, 8'h00, 32'h0, 4'hF, "wr_ctrl0", rd);

`ifdef APB_PSTRB_EN
      do_xfer(1'b1, 8'h0C, 32'h1122_3344, 4'hF, "strb_init", rd);
      do_xfer(1'b1, 8'h0C, 32'hAABB_CCDD, 4'b0101, "strb_wr", rd);
      do_xfer(1'b0, 8'h0C, 32'h0, 4'hF, "strb_rd", rd);
      check("strb_rd/value", rd, 32'h11BB_33DD);
      do_xfer(1'b1, 8'h0C, 32'hFFFF_FFFF, 4'b0000, "strb_none", rd);
      do_xfer(1'b0, 8'h0C, 32'h0, 4'hF, "strb_none_rd", rd);
`endif

      for (int n = 0; n < 40; n++) begin
         w = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) a = 8'($urandom);
         else                           a = 8'($urandom_range(0, 15) << 2);
         if (a == 8'h00 && $urandom_range(0, 1) == 0) d = 32'($urandom_range(0, 9));
         else                                         d = $urandom;
         s = 4'($urandom);
         do_xfer(w, a, d, s, "random", rd);
      end

      do_xfer(1'b1, 8'h00, 32'h3, 4'hF, "abort_ctrl3", rd);
      do_xfer(1'b1, 8'h18, 32'h5A5A_A5A5, 4'hF, "abort_pre", rd);
      // Abandon a write to idx 6 midway through its wait states
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h18; pwdata = 32'hCAFE_F00D;
`ifdef APB_PSTRB_EN
      pstrb = 4'hF;
`endif
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      check("abort/pready1", pready, 1'b0);
      @(posedge pclk); #1;
      @(negedge pclk);
      check("abort/pready2", pready, 1'b0);
      go_idle();
      do_xfer(1'b0, 8'h18, 32'h0, 4'hF, "abort_rd_idx6", rd);
      do_xfer(1'b0, 8'h04, 32'h0, 4'hF, "abort_rd_status", rd);

      // Reset during the wait states of a write
      do_xfer(1'b1, 8'h1C, 32'h0BAD_0BAD, 4'hF, "rst_pre", rd);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h1C; pwdata = 32'h1234_5678;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      prst = 1'b0;
      @(negedge pclk);
      check("midrst/pready", pready, 1'b0);
      check("midrst/pslverr", pslverr, 1'b0);
      check("midrst/prdata", prdata, 32'h0);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      prst = 1'b1;
      model_reset();
      do_xfer(1'b0, 8'h00, 32'h0, 4'hF, "postrst_ctrl", rd);
      do_xfer(1'b0, 8'h1C, 32'h0, 4'hF, "postrst_idx7", rd);
      do_xfer(1'b0, 8'h0C, 32'h0, 4'hF, "postrst_idx3", rd);
      do_xfer(1'b0, 8'h18, 32'h0, 4'hF, "postrst_idx6", rd);
      do_xfer(1'b0, 8'h04, 32'h0, 4'hF, "postrst_status", rd);
      go_idle();
      repeat (2) @(posedge pclk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/apb_param_slave.md
Name: apb_param_slave

Overview:
Parametrised APB completer holding a small register file. It is the next generation of the fixed 8-bit, zero-wait slave used by the APB verification bench.
- Generalises address and data width and register depth.
- Adds programmable wait states, address and access-type error reporting via PSLVERR, and hardware transfer/error counters.
- Sits on the APB bus behind the bench driver; its pins map onto the APB interface signals.

Parameters:
ADDR_W, 8, address width in bits
DATA_W, 32, data width in bits; must be 16, 32 or 64
NUM_REGS, 16, number of word registers; must be >= 3
MAX_WAIT, 7, largest programmable wait-state count; WAIT_W = $clog2(MAX_WAIT+1)

Ports:
pclk  in  1  clock
prst  in  1  asynchronous active-low reset; one clock domain (pclk)
psel  in  1  completer select
penable  in  1  access phase strobe
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_W  byte address
pwdata  in  DATA_W  write data
pstrb  in  DATA_W/8  byte write strobes (present only with APB_PSTRB_EN)
prdata  out  DATA_W  read data
pready  out  1  transfer complete
pslverr  out  1  transfer error, valid only with pready

Behaviour:
- Reset (prst low, asynchronous), all outputs and state cleared:
  - prdata = 0, pready = 0, pslverr = 0
  - all registers = 0, FSM = IDLE, wait counter = 0
- Address decode:
  - LSB = $clog2(DATA_W/8); idx = paddr >> LSB.
  - Error if paddr[LSB-1:0] != 0 (misaligned) or idx >= NUM_REGS.
- Register map:
  - idx 0 CTRL: RW; bits [WAIT_W-1:0] = wait states; written values above MAX_WAIT saturate to MAX_WAIT; other bits read 0.
  - idx 1 STATUS: RO; [DATA_W/2-1:0] = completed transfer count, upper half = error count; both saturate at all-ones. A write to it is an error and has no effect.
  - idx 2..NUM_REGS-1: general RW.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on psel && !penable (setup cycle). The wait counter loads from CTRL at that moment.
  - In ACCESS with psel && penable:
    - If wcnt != 0: decrement wcnt; pready stays 0.
    - If wcnt == 0: pready = 1 this cycle, then return to IDLE.
  - Back-to-back transfers re-enter ACCESS from the next setup cycle.
- pready and pslverr are combinational from registered state and the current inputs.
  - pready = 0 outside the completion cycle.
  - The access phase lasts exactly CTRL.wait + 1 cycles; with wait = 0 this is the zero-wait behaviour.
- Completion cycle:
  - Write without error: commit pwdata (byte-masked when strobes are enabled).
  - Read without error: prdata = register value.
  - Error: pslverr = 1, nothing written, prdata = 0.
  - prdata = 0 whenever pready = 0.
- Counters: every completion increments the transfer count; error completions also increment the error count. Both update at the clock edge ending the completion cycle.
- A write to CTRL affects only subsequent transfers; the current transfer's wait count is already loaded.
- Abort: psel falls while in ACCESS -> return to IDLE; no write, no counter update.
- Protocol violation: penable high in IDLE is ignored, and the FSM waits for a proper setup cycle.
- Reset mid-transfer aborts it; no partial write occurs.

Optional Feature:
APB_PSTRB_EN
- Defined: pstrb port exists. Byte lane i is written only when pstrb[i] = 1. A write with pstrb = 0 completes without error and changes nothing. pstrb is ignored on reads.
- Undefined: no pstrb port; all writes are full-word.

Decomposition:
- Package apb_param_pkg contains:
  - state enum {IDLE, ACCESS}
  - CTRL_IDX = 0 and STATUS_IDX = 1
  - function computing the LSB shift from DATA_W
- Sub-module apb_sat_counter (parameter W; inputs inc, clear via reset), instantiated twice for the transfer and error counts.

Test Plan:
- Reset, then read idx 2 (paddr 0x08) with wait 0 -> pready in the first access cycle, prdata 0x0000_0000, pslverr 0.
- Write CTRL = 3, then write 0xDEAD_BEEF to paddr 0x0C -> pready after 4 access cycles; read back returns 0xDEAD_BEEF after 4 cycles.
- Write CTRL = 0xFF -> CTRL reads back 7; the next transfer takes 8 access cycles.
- Read paddr 0x40 (idx 16), read paddr 0x09 (misaligned), write STATUS -> each gives pslverr = 1 on the pready cycle; STATUS error count = 3.
- With APB_PSTRB_EN: idx 3 = 0x1122_3344, write 0xAABB_CCDD with pstrb 4'b0101 -> reads 0x11BB_33DD.
- With wait 3: drop psel after 2 access cycles -> no write, no counter change; assert prst during the wait -> pready 0 and all registers 0.
